check_dup_rd: RTL and testbench
===============================

Name: check_dup_rd

Overview:
- Dual-issue hazard detector for the MIPS superscalar front end.
- Compares the destination register of issue-slot-1 instruction (rd_1) against both source registers (rs_2, rt_2) of issue-slot-2 instruction in the same fetch pair.
- Flags a read-after-write dependency so issue logic serialises the pair (change_instr).
- Also provides registered copies and a saturating hazard counter for performance monitoring.

Parameters:
- AWIDTH, 5, register-address width; equals global `AWIDTH (32-entry MIPS register file).
- CWIDTH, 16, width of the hazard event counter.

Ports:
- cd_i_clk  input  1  system clock, rising edge
- cd_i_rst_n  input  1  asynchronous active-low reset
- cd_i_addr_rd_1  input  AWIDTH  destination register of slot-1 instruction
- cd_i_addr_rs_2  input  AWIDTH  rs source of slot-2 instruction
- cd_i_addr_rt_2  input  AWIDTH  rt source of slot-2 instruction
- cd_o_change_instr  output  1  combinational dependency flag (match_rs OR match_rt)
- cd_o_match_rs  output  1  combinational: rd_1 == rs_2 and rd_1 != 0
- cd_o_match_rt  output  1  combinational: rd_1 == rt_2 and rd_1 != 0
- cd_o_change_instr_q  output  1  cd_o_change_instr registered one cycle
- cd_o_dup_count  output  CWIDTH  saturating count of cycles with change_instr high

Behaviour:
- Combinational path:
  - cd_o_match_rs, cd_o_match_rt and cd_o_change_instr are purely combinational.
  - They have zero latency and no dependence on cd_i_clk or cd_i_rst_n.
  - They update in the same timestep as the address inputs.
- Register 0 ($zero) exclusion:
  - When rd_1 == 0, all match outputs are 0, regardless of rs_2/rt_2.
  - Writes to $zero create no dependency.
- Equality is a full AWIDTH-bit compare. No partial or masked matching.
- change_instr = match_rs | match_rt. Both sources matching (rs_2 == rt_2 == rd_1) still gives a single 1.
- X/Z handling:
  - Inputs containing X/Z produce X outputs per normal Verilog equality semantics.
  - No special-case logic is added.
- Registered path:
  - cd_o_change_instr_q <= cd_o_change_instr on each rising cd_i_clk.
  - Latency is exactly 1 cycle.
- Counter:
  - cd_o_dup_count increments by 1 on each rising edge where cd_o_change_instr == 1.
  - It saturates at 2^CWIDTH-1 and never wraps.
- Reset:
  - cd_i_rst_n low asynchronously forces cd_o_change_instr_q = 0 and cd_o_dup_count = 0.
  - Release is synchronous to the next rising edge.
  - Combinational outputs are unaffected by reset.
  - Reset asserted mid-count clears the counter immediately.
- No handshake and no state machine.

Decomposition:
- Shared package/header: `AWIDTH define (5) and the register-zero constant, used by decode and issue logic.
- One sub-module is natural: reg_cmp (AWIDTH-wide equality compare with zero-register qualification), instantiated twice (rs and rt).
- The counter and pipeline register stay in the top module.

Test Plan:
- All inputs 0: rd_1=0, rs_2=0, rt_2=0 -> change_instr=0 ($zero excluded).
- No match: rd_1=5, rs_2=9, rt_2=10 -> match_rs=0, match_rt=0, change_instr=0.
- rs match: rd_1=5, rs_2=5, rt_2=10 -> match_rs=1, match_rt=0, change_instr=1 in same timestep; change_instr_q=1 after next rising edge.
- rt match: rd_1=5, rs_2=9, rt_2=5 -> match_rs=0, match_rt=1, change_instr=1.
- Both match: rd_1=5, rs_2=5, rt_2=5 -> match_rs=1, match_rt=1, change_instr=1.
  - Over 3 clock edges dup_count goes 0→3.
  - Assert rst_n=0 mid-cycle -> dup_count=0 and change_instr_q=0 immediately; change_instr stays 1.
- Saturation: CWIDTH=2, hold a match for 6 edges -> dup_count sticks at 3.

Source files
------------

// File: rtl/check_dup_rd_pkg.sv
// Shared register-address constants for the dual-issue front end.
// Decode, issue and hazard logic import these for address width and the $zero index.
package check_dup_rd_pkg;

    localparam int AWIDTH = 5;
    localparam int CWIDTH = 16;

    localparam logic [AWIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/check_dup_rd_reg_cmp.sv
// Full-width register-address equality.
// A destination of $zero never matches, because writes to $zero are discarded.
module check_dup_rd_reg_cmp
    import check_dup_rd_pkg::*;
#(
    parameter int AW = AWIDTH
) (
    input  logic [AW-1:0] rd_i,
    input  logic [AW-1:0] src_i,
    output logic          match_o
);

    // Plain == keeps X/Z propagation.
    assign match_o = (rd_i == src_i) && (rd_i != AW'(REG_ZERO));

endmodule

// File: rtl/check_dup_rd.sv
// RAW hazard detector between slot-1 destination and slot-2 sources of a fetch pair.
// The combinational flags feed issue; the registered flag and event counter feed perf monitoring.
module check_dup_rd
    import check_dup_rd_pkg::*;
#(
    parameter int AWIDTH = check_dup_rd_pkg::AWIDTH,
    parameter int CWIDTH = check_dup_rd_pkg::CWIDTH
) (
    input  logic              cd_i_clk,
    input  logic              cd_i_rst_n,
    input  logic [AWIDTH-1:0] cd_i_addr_rd_1,
    input  logic [AWIDTH-1:0] cd_i_addr_rs_2,
    input  logic [AWIDTH-1:0] cd_i_addr_rt_2,
    output logic              cd_o_change_instr,
    output logic              cd_o_match_rs,
    output logic              cd_o_match_rt,
    output logic              cd_o_change_instr_q,
    output logic [CWIDTH-1:0] cd_o_dup_count
);

    logic              change_q;
    logic [CWIDTH-1:0] count_q;
    logic [CWIDTH-1:0] count_d;

    check_dup_rd_reg_cmp #(.AW(AWIDTH)) u_cmp_rs (
        .rd_i    (cd_i_addr_rd_1),
        .src_i   (cd_i_addr_rs_2),
        .match_o (cd_o_match_rs)
    );

    check_dup_rd_reg_cmp #(.AW(AWIDTH)) u_cmp_rt (
        .rd_i    (cd_i_addr_rd_1),
        .src_i   (cd_i_addr_rt_2),
        .match_o (cd_o_match_rt)
    );

    assign cd_o_change_instr = cd_o_match_rs | cd_o_match_rt;

    always_comb begin
        count_d = count_q;
        // Saturate at all-ones so the perf counter never wraps back to a small value.
        if (cd_o_change_instr && (count_q != {CWIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cd_i_clk or negedge cd_i_rst_n) begin
        if (!cd_i_rst_n) begin
            change_q <= 1'b0;
            count_q  <= '0;
        end else begin
            change_q <= cd_o_change_instr;
            count_q  <= count_d;
        end
    end

    assign cd_o_change_instr_q = change_q;
    assign cd_o_dup_count      = count_q;

endmodule

// File: tb/tb_check_dup_rd.sv
// Scoreboard bench for check_dup_rd: directed pairs, reset, saturation, then random pairs.
// A second instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_check_dup_rd;

    localparam int AW     = 5;
    localparam int CW     = 16;
    localparam int CW_SAT = 2;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rd_1, rs_2, rt_2;

    logic          change, match_rs, match_rt, change_q;
    logic [CW-1:0] dup_count;
    logic          s_change, s_match_rs, s_match_rt, s_change_q;
    logic [CW_SAT-1:0] s_dup_count;

    check_dup_rd #(.AWIDTH(AW), .CWIDTH(CW)) u_dut (
        .cd_i_clk            (clk),
        .cd_i_rst_n          (rst_n),
        .cd_i_addr_rd_1      (rd_1),
        .cd_i_addr_rs_2      (rs_2),
        .cd_i_addr_rt_2      (rt_2),
        .cd_o_change_instr   (change),
        .cd_o_match_rs       (match_rs),
        .cd_o_match_rt       (match_rt),
        .cd_o_change_instr_q (change_q),
        .cd_o_dup_count      (dup_count)
    );

    check_dup_rd #(.AWIDTH(AW), .CWIDTH(CW_SAT)) u_sat (
        .cd_i_clk            (clk),
        .cd_i_rst_n          (rst_n),
        .cd_i_addr_rd_1      (rd_1),
        .cd_i_addr_rs_2      (rs_2),
        .cd_i_addr_rt_2      (rt_2),
        .cd_o_change_instr   (s_change),
        .cd_o_match_rs       (s_match_rs),
        .cd_o_match_rt       (s_match_rt),
        .cd_o_change_instr_q (s_change_q),
        .cd_o_dup_count      (s_dup_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        match_rs;
        logic        match_rt;
        logic        change;
        logic        change_q;
        int unsigned count;
        int unsigned count_sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: what the registered outputs hold after the most recent edge.
    bit          m_change_q  = 0;
    int unsigned m_count     = 0;
    int unsigned m_count_sat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one fetch pair just after a falling edge and predict everything visible before the next rising edge.
    task automatic step(input bit rst, input int rd, input int rs, input int rt);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        rd_1  = AW'(rd);
        rs_2  = AW'(rs);
        rt_2  = AW'(rt);
        if (!rst) begin
            m_change_q  = 0;
            m_count     = 0;
            m_count_sat = 0;
        end
        e.match_rs  = (rd != 0) && (rd == rs);
        e.match_rt  = (rd != 0) && (rd == rt);
        e.change    = e.match_rs || e.match_rt;
        e.change_q  = m_change_q;
        e.count     = m_count;
        e.count_sat = m_count_sat;
        exp_q.push_back(e);
        if (rst) begin
            m_change_q = e.change;
            if (e.change) begin
                if (m_count < (2**CW - 1))     m_count++;
                if (m_count_sat < (2**CW_SAT - 1)) m_count_sat++;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("match_rs",   32'(match_rs),    32'(e.match_rs));
                check("match_rt",   32'(match_rt),    32'(e.match_rt));
                check("change",     32'(change),      32'(e.change));
                check("change_q",   32'(change_q),    32'(e.change_q));
                check("dup_count",  32'(dup_count),   e.count);
                check("sat_change", 32'(s_change),    32'(e.change));
                check("sat_count",  32'(s_dup_count), e.count_sat);
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst_n = 1'b0;
        rd_1  = '0;
        rs_2  = '0;
        rt_2  = '0;

        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 5, 9, 10);
        step(1, 5, 5, 10);
        step(1, 5, 9, 5);
        step(1, 0, 0, 0);
        step(1, 5, 5, 5);
        step(1, 5, 5, 5);
        step(1, 5, 5, 5);
        step(1, 5, 5, 5);
        step(0, 5, 5, 5);
        for (int i = 0; i < 7; i++) step(1, 5, 5, 5);
        step(1, 31, 15, 30);
        step(1, 16, 0, 16);
        step(1, 31, 31, 1);
        step(1, 0, 7, 7);

        for (int i = 0; i < 300; i++) begin
            bit rst;
            int lim;
            rst = ($urandom_range(0, 39) != 0);
            lim = ($urandom_range(0, 3) == 0) ? 31 : 6;
            step(rst, $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim));
        end
        step(1, 0, 0, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

endmodule
